// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the two data-memory requesters of dmem_arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_ack;
  logic        m0_done;
  logic        m0_err;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_ack;
  logic        m1_done;
  logic        m1_err;
  logic [31:0] m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m0_ack, m0_done, m0_err, m0_rdata,
    input  m1_ack, m1_done, m1_err, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m0_ack, m0_done, m0_err, m0_rdata,
    output m1_ack, m1_done, m1_err, m1_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a small data memory.
// Each access takes IDLE -> ACCESS -> DONE; out-of-range addresses complete with err.
module dmem_arbiter #(
  parameter int unsigned ADDR_MAX = 57
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arbiter_if.slave bus,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        last_grant;
  logic        owner_p0;
  logic        we_p0;
  logic        legal_p0;

  logic        ack0;
  logic        ack1;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_legal;

  logic        done0, done1;
  logic        err0, err1;
  logic [31:0] rdata0, rdata1;

  // On a tie the port that was not granted last wins (last_grant=1 means m1 went last).
  assign ack0 = (state == IDLE) && !reset && bus.m0_req && (!bus.m1_req || last_grant);
  assign ack1 = (state == IDLE) && !reset && bus.m1_req && (!bus.m0_req || !last_grant);

  assign sel_we    = ack1 ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = ack1 ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = ack1 ? bus.m1_wdata : bus.m0_wdata;
  assign sel_legal = (sel_addr <= ADDR_MAX);

  assign bus.m0_ack   = ack0;
  assign bus.m1_ack   = ack1;
  assign bus.m0_done  = done0;
  assign bus.m1_done  = done1;
  assign bus.m0_err   = err0;
  assign bus.m1_err   = err1;
  assign bus.m0_rdata = rdata0;
  assign bus.m1_rdata = rdata1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner_p0   <= 1'b0;
      we_p0      <= 1'b0;
      legal_p0   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        // Grant edge: latch the winner's command and launch the strobe
        IDLE: begin
          if (ack0 || ack1) begin
            state      <= ACCESS;
            busy       <= 1'b1;
            last_grant <= ack1;
            owner_p0   <= ack1;
            we_p0      <= sel_we;
            legal_p0   <= sel_legal;
            mem_read   <= sel_legal && !sel_we;
            mem_write  <= sel_legal && sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
          end
        end
        // Access edge: capture read data, raise the owner's completion
        ACCESS: begin
          state     <= DONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          done0     <= !owner_p0;
          done1     <= owner_p0;
          err0      <= !owner_p0 && !legal_p0;
          err1      <= owner_p0 && !legal_p0;
          rdata0    <= (!owner_p0 && legal_p0 && !we_p0) ? mem_rdata : 32'd0;
          rdata1    <= (owner_p0 && legal_p0 && !we_p0) ? mem_rdata : 32'd0;
        end
        // Completion edge: retire the pulse and return to arbitration
        DONE: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          err0   <= 1'b0;
          err1   <= 1'b0;
          rdata0 <= '0;
          rdata1 <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: writes/reads, round-robin ties, range errors,
// reset mid-access and a held request from the idle port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus();

  dmem_arbiter #(.ADDR_MAX(57)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  // Memory model: word i preloads to 0xA500_0000 | i while reset is high.
  logic [31:0] mem_model [0:63];
  assign mem_rdata = mem_model[mem_addr[5:0]];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_write) begin
      mem_model[mem_addr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Single transaction starting at the negedge of an IDLE cycle; returns at the next IDLE negedge.
  task automatic txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit exp_rd, input bit exp_wr, input logic [31:0] exp_rdata, input bit exp_err);
    if (!port) begin
      bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_req = 1'b1;
    end else begin
      bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_req = 1'b1;
    end
    #1;
    chk("txn_ack",       port ? bus.m1_ack : bus.m0_ack, 1);
    chk("txn_other_ack", port ? bus.m0_ack : bus.m1_ack, 0);
    step();
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    #1;
    chk("txn_mem_read",  mem_read,  32'(exp_rd));
    chk("txn_mem_write", mem_write, 32'(exp_wr));
    chk("txn_mem_addr",  mem_addr,  addr);
    if (exp_wr) chk("txn_mem_wdata", mem_wdata, wdata);
    chk("txn_busy",      busy, 1);
    chk("txn_ack_access", bus.m0_ack | bus.m1_ack, 0);
    step();
    #1;
    chk("txn_done",        port ? bus.m1_done  : bus.m0_done,  1);
    chk("txn_other_done",  port ? bus.m0_done  : bus.m1_done,  0);
    chk("txn_err",         port ? bus.m1_err   : bus.m0_err,   32'(exp_err));
    chk("txn_rdata",       port ? bus.m1_rdata : bus.m0_rdata, exp_rdata);
    chk("txn_other_rdata", port ? bus.m0_rdata : bus.m1_rdata, 0);
    chk("txn_strobe_off",  mem_read | mem_write, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    repeat (3) step();
    #1;
    chk("rst_ack0",  bus.m0_ack, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_rd",    mem_read | mem_write, 0);
    chk("rst_done",  bus.m0_done | bus.m1_done, 0);
    chk("rst_addr",  mem_addr, 0);
    chk("rst_rdata", bus.m0_rdata, 0);
    step();
    reset = 1'b0;
    bus.m0_req = 1'b0;

    // Write then read back through m0
    txn(0, 1, 32'd8,  32'hDEAD_BEEF, 0, 1, 32'h0,         0);
    txn(0, 0, 32'd8,  32'h0,         1, 0, 32'hDEAD_BEEF, 0);
    // Address range boundaries on m1
    txn(1, 0, 32'd58, 32'h0,         0, 0, 32'h0,         1);
    txn(1, 0, 32'd57, 32'h0,         1, 0, 32'hA500_0039, 0);
    txn(1, 1, 32'h8000_0000, 32'h1234_5678, 0, 0, 32'h0,  1);

    // Fresh reset, then both ports request continuously: m0, m1, m0, m1
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd4;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd12;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ack0", bus.m0_ack, 32'(k % 2 == 0));
      chk("rr_ack1", bus.m1_ack, 32'(k % 2 == 1));
      step();
      #1;
      chk("rr_acks_access", bus.m0_ack | bus.m1_ack, 0);
      chk("rr_addr", mem_addr, (k % 2 == 0) ? 32'd4 : 32'd12);
      step();
      #1;
      chk("rr_acks_done", bus.m0_ack | bus.m1_ack, 0);
      chk("rr_done", (k % 2 == 0) ? bus.m0_done : bus.m1_done, 1);
      chk("rr_rdata", (k % 2 == 0) ? bus.m0_rdata : bus.m1_rdata,
          (k % 2 == 0) ? 32'hA500_0004 : 32'hA500_000C);
      step();
    end
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;

    // Reset during the ACCESS cycle of an m0 read
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd16;
    #1 chk("rstacc_ack0", bus.m0_ack, 1);
    step();
    bus.m0_req = 1'b0;
    reset = 1'b1;
    #1 chk("rstacc_strobe", mem_read, 1);
    chk("rstacc_ack_in_reset", bus.m0_ack | bus.m1_ack, 0);
    step();
    reset = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd20;
    #1;
    chk("rstacc_busy",  busy, 0);
    chk("rstacc_rd",    mem_read, 0);
    chk("rstacc_done0", bus.m0_done, 0);
    chk("rstacc_addr",  mem_addr, 0);
    chk("rstacc_ack1",  bus.m1_ack, 1);
    step();
    bus.m1_req = 1'b0;
    #1;
    chk("rstacc_m1_rd",  mem_read, 1);
    chk("rstacc_m1_addr", mem_addr, 32'd20);
    chk("rstacc_done0b", bus.m0_done, 0);
    step();
    #1;
    chk("rstacc_m1_done",  bus.m1_done, 1);
    chk("rstacc_m1_rdata", bus.m1_rdata, 32'hA500_0014);
    chk("rstacc_done0c",   bus.m0_done, 0);
    step();

    // m1 holds its request while m0 is served (m1 went last, so m0 wins the tie)
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'd24;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'd28;
    #1;
    chk("hold_T_ack0", bus.m0_ack, 1);
    chk("hold_T_ack1", bus.m1_ack, 0);
    step();
    bus.m0_req = 1'b0;
    #1 chk("hold_T1_ack1", bus.m1_ack, 0);
    step();
    #1;
    chk("hold_T2_ack1",  bus.m1_ack, 0);
    chk("hold_T2_done0", bus.m0_done, 1);
    chk("hold_T2_rdata", bus.m0_rdata, 32'hA500_0018);
    step();
    #1 chk("hold_T3_ack1", bus.m1_ack, 1);
    step();
    bus.m1_req = 1'b0;
    #1;
    chk("hold_T4_rd",   mem_read, 1);
    chk("hold_T4_addr", mem_addr, 32'd28);
    step();
    #1;
    chk("hold_T5_done1", bus.m1_done, 1);
    chk("hold_T5_rdata", bus.m1_rdata, 32'hA500_001C);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_MAX, default 57, meaning the highest legal byte address for a 4-byte access (61-byte data memory, addr+3 <= 60).
REQ-002 The block SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports m0_req and m1_req, input, 1 each, meaning a request is pending and is held until acked.
REQ-005 The block SHALL have ports m0_we and m1_we, input, 1 each, meaning 1=write and 0=read.
REQ-006 The block SHALL have ports m0_addr and m1_addr, input, 32 each, meaning the byte address.
REQ-007 The block SHALL have ports m0_wdata and m1_wdata, input, 32 each, meaning the write word.
REQ-008 The block SHALL have ports m0_ack and m1_ack, output, 1 each, meaning the command is accepted this cycle (combinational).
REQ-009 The block SHALL have ports m0_done and m1_done, output, 1 each, meaning a one-cycle completion pulse (registered).
REQ-010 The block SHALL have ports m0_err and m1_err, output, 1 each, qualified by the matching done and meaning the address was out of range.
REQ-011 The block SHALL have ports m0_rdata and m1_rdata, output, 32 each, meaning read data qualified by done.
REQ-012 The block SHALL have ports mem_read and mem_write, output, 1 each, registered memory strobes.
REQ-013 The block SHALL have ports mem_addr and mem_wdata, output, 32 each, registered memory command.
REQ-014 The block SHALL have port mem_rdata, input, 32, combinational read data from memory.
REQ-015 The block SHALL have port busy, output, 1, meaning the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS and DONE; transitions SHALL be IDLE->ACCESS on any req, ACCESS->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-017 In IDLE with exactly one req high, that port SHALL be acked combinationally in the same cycle.
REQ-018 In IDLE with both reqs high, the port not granted last SHALL win; the last_grant register SHALL update to the winner on each grant.
REQ-019 At most one ack SHALL be high in any cycle, and acks SHALL be 0 outside IDLE and while reset is high.
REQ-020 On the IDLE->ACCESS edge, the winner's we/addr/wdata and port id SHALL be latched; the requester may drop req after that edge.
REQ-021 In ACCESS, mem_addr and mem_wdata SHALL hold the latched values, and exactly one of mem_read or mem_write SHALL be 1 for exactly one cycle.
REQ-022 An access with addr > ADDR_MAX (unsigned 32-bit compare) SHALL assert neither strobe in ACCESS and SHALL complete with err=1 and rdata=0.
REQ-023 For a legal read, mem_rdata SHALL be captured at the ACCESS->DONE edge and presented on the owner's rdata during DONE.
REQ-024 For a write, rdata SHALL be 0 in DONE.
REQ-025 In DONE, only the owner's done SHALL be 1 for exactly one cycle; the other port's done, err and rdata SHALL be 0.
REQ-026 Latency SHALL be: req/ack at cycle T, strobe at T+1, done at T+2, next arbitration at T+3; peak throughput SHALL be one access per 3 cycles.
REQ-027 A req asserted during ACCESS or DONE SHALL be held and served no earlier than the next IDLE cycle.
REQ-028 Back-to-back requests from both ports SHALL strictly alternate grants.

Reset
REQ-029 While reset is high, at each clock edge the state SHALL become IDLE and last_grant SHALL become 1, so m0 wins the first tie.
REQ-030 On reset, mem_read, mem_write, all done, all err and busy SHALL clear to 0, and mem_addr, mem_wdata and all rdata SHALL clear to 0.
REQ-031 A reset asserted during ACCESS or DONE SHALL drop the transaction: no done SHALL be asserted for it, and any strobe SHALL deassert at the reset edge.

Verification
REQ-032 m0 writes 0xDEADBEEF to address 8, then reads address 8 -> mem_write=1 at T+1 with mem_addr=8, m0_done at T+2; the read returns m0_rdata=0xDEADBEEF with err=0.
REQ-033 m0 and m1 both request in the same IDLE cycle right after reset, and keep requesting -> grants go m0, m1, m0, m1 at 3-cycle spacing, never both acks high.
REQ-034 m1 reads address 58 -> no strobe in ACCESS, m1_done=1, m1_err=1, m1_rdata=0; address 57 reads with err=0.
REQ-035 Reset is asserted in the ACCESS cycle of an m0 read -> no m0_done, state IDLE, all outputs 0 after the edge; the next m1 request is acked in the first IDLE cycle.
REQ-036 m1 holds req continuously while m0 is served -> m1 is acked exactly at T+3 and m1_done follows at T+5.
